complete_arbiter: RTL and testbench
===================================

COMPLETE_ARBITER -- requirements
Module: complete_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of execution-unit requesters (0=ALU, 1=MUL, 2=LD).
REQ-002 SHALL have parameter ROB_W, default 4, ROB index width (16 entries).
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: req_valid  in  NUM_REQ  requester i has a completed instruction.
REQ-006 SHALL have ports: req_ready  out  NUM_REQ  holding slot i empty, capture allowed.
REQ-007 SHALL have ports: req_rob  in  NUM_REQ*ROB_W  ROB number per requester, packed, slot 0 in LSBs.
REQ-008 SHALL have ports: req_cf  in  NUM_REQ  instruction is a mispredicted branch or jump.
REQ-009 SHALL have ports: req_addr  in  NUM_REQ*32  corrected target per requester, packed.
REQ-010 SHALL have ports: rob_head  in  ROB_W  ROB head index, the oldest in-flight entry.
REQ-011 SHALL have ports: recover  in  1  ROB rollback in progress.
REQ-012 SHALL have ports: changeFlow_out  in  1  ROB end-of-recovery pulse.
REQ-013 SHALL have ports: complete  out  1  drive ROB complete port.
REQ-014 SHALL have ports: rob_number  out  ROB_W  ROB entry being completed.
REQ-015 SHALL have ports: changeFlow  out  1  completing entry triggers recovery.
REQ-016 SHALL have ports: jb_addr  out  32  target for changeFlow.
REQ-017 SHALL have ports: grant_id  out  2  index of the granted slot.
REQ-018 SHALL have ports: rec_busy  out  1  high in CF_WAIT or RECOVER.

Function
REQ-019 SHALL keep one holding slot per requester {valid, rob, cf, addr}; req_ready[i] = !slot_valid[i]; capture on req_valid[i] && req_ready[i].
REQ-020 SHALL drive complete, rob_number, changeFlow, jb_addr and grant_id only from slot registers and state, with no combinational path from req_* or recover; minimum latency is capture at edge N and complete in cycle N.
REQ-021 SHALL compute age_i = (slot_rob_i - rob_head) mod 2^ROB_W, and in NORMAL grant the valid slot with minimum age, breaking ties by lowest index.
REQ-022 SHALL clear the granted slot at the grant edge; that slot cannot refill in the same cycle.
REQ-023 SHALL use FSM NORMAL -> CF_WAIT when the granted slot has cf=1, latching branch_age = age of the granted slot.
REQ-024 SHALL grant nothing in CF_WAIT; it SHALL move CF_WAIT -> RECOVER when recover=1.
REQ-025 SHALL grant nothing in RECOVER; it SHALL move RECOVER -> NORMAL on changeFlow_out=1.
REQ-026 SHALL, at the cf grant edge and every edge in CF_WAIT or RECOVER, invalidate any slot with age > branch_age.
REQ-027 SHALL accept (ready=1) but discard any incoming capture with age > branch_age in those same states.
REQ-028 SHALL keep slots with age < branch_age held and granted in age order after returning to NORMAL.
REQ-029 SHALL grant only the older of two valid cf slots; the younger is flushed per REQ-026.
REQ-030 SHALL have complete=0 and changeFlow=0 whenever no slot is valid or state != NORMAL; rob_number, jb_addr and grant_id are don't-care then but held at their last value.

Reset
REQ-031 SHALL, on rst=1 (asynchronous, including mid-recovery): clear all slots, set state=NORMAL, branch_age=0, and drive all outputs 0 except req_ready=all-ones.

Structure
REQ-032 SHALL place the FSM state enum (NORMAL, CF_WAIT, RECOVER), ROB_W, NUM_REQ and the requester index constants in the shared pipeline package.
REQ-033 SHALL implement the minimum-age selector as the sub-module age_select, which is combinational, NUM_REQ-wide, and returns the index and a found flag.

Verification
REQ-034 SHALL cover: head=14, ALU rob=1 and MUL rob=15 captured together -> MUL granted first (age 1), ALU next cycle (age 3).
REQ-035 SHALL cover: ALU rob=3 with cf=1 and addr=0x40 granted while LD holds rob=5 -> changeFlow=1, jb_addr=0x40, LD slot cleared, state CF_WAIT.
REQ-036 SHALL cover: MUL rob=2 (older) pending during the REQ-035 recovery -> held through RECOVER, granted the cycle after changeFlow_out.
REQ-037 SHALL cover: two cf slots (rob=6, rob=8) with head=4 -> only rob=6 completes; rob=8 is never granted.
REQ-038 SHALL cover: rst asserted in RECOVER with 2 slots full -> next cycle state NORMAL, complete=0, req_ready=3'b111.
REQ-039 SHALL cover: all three slots full with head=0 and robs 9, 10, 11 -> three consecutive grants in order 9, 10, 11, with no bubble.

Source files
------------

// File: rtl/complete_arbiter_pkg.sv
// Shared pipeline definitions for the completion arbiter: requester
// indices, default widths and the recovery FSM state encoding.
package complete_arbiter_pkg;

  localparam int NUM_REQ = 3;   // execution-unit requesters
  localparam int ROB_W   = 4;   // ROB index width (16 entries)
  localparam int ID_W    = 2;   // width of a requester index

  localparam int REQ_ALU = 0;
  localparam int REQ_MUL = 1;
  localparam int REQ_LD  = 2;

  // NORMAL: granting by age. CF_WAIT: mispredict completed, waiting for
  // the ROB to start rolling back. RECOVER: rollback in progress.
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    CF_WAIT = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/complete_arbiter_age_select.sv
// Combinational minimum-age selector: returns the index of the valid entry
// with the smallest age, lowest index winning ties, plus a found flag.
module age_select #(
  parameter int N    = 3,
  parameter int W    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [N*W-1:0] age,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  logic [W-1:0] best_age;

  // Linear scan; strict less-than keeps the lower index on equal ages.
  always_comb begin
    idx      = '0;
    found    = 1'b0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (!found || (age[i*W +: W] < best_age))) begin
        found    = 1'b1;
        best_age = age[i*W +: W];
        idx      = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Completion arbiter: one holding slot per execution unit, oldest-first
// grant to the ROB complete port, and flush of younger work while a
// mispredicted branch/jump is being recovered.
//
// Handshake: requester i transfers on a rising edge where
// req_valid[i] && req_ready[i]; req_ready[i] is high exactly when slot i
// is empty. A transfer during recovery that is younger than the branch is
// accepted and dropped.
module complete_arbiter #(
  parameter int NUM_REQ = complete_arbiter_pkg::NUM_REQ,
  parameter int ROB_W   = complete_arbiter_pkg::ROB_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*ROB_W-1:0] req_rob,
  input  logic [NUM_REQ-1:0]       req_cf,
  input  logic [NUM_REQ*32-1:0]    req_addr,
  input  logic [ROB_W-1:0]         rob_head,
  input  logic                     recover,
  input  logic                     changeFlow_out,
  output logic                     complete,
  output logic [ROB_W-1:0]         rob_number,
  output logic                     changeFlow,
  output logic [31:0]              jb_addr,
  output logic [1:0]               grant_id,
  output logic                     rec_busy
);

  import complete_arbiter_pkg::*;

  arb_state_t state, state_next;

  logic [NUM_REQ-1:0]       slot_valid;
  logic [NUM_REQ-1:0]       slot_cf;
  logic [ROB_W-1:0]         slot_rob  [NUM_REQ];
  logic [31:0]              slot_addr [NUM_REQ];
  logic [ROB_W-1:0]         slot_age  [NUM_REQ];
  logic [ROB_W-1:0]         in_age    [NUM_REQ];
  logic [NUM_REQ*ROB_W-1:0] age_flat;

  logic [ID_W-1:0]  sel_idx;
  logic             sel_found;
  logic [ROB_W-1:0] sel_age;
  logic [ROB_W-1:0] branch_age;
  logic [ROB_W-1:0] flush_age;
  logic             grant;
  logic             grant_cf;
  logic             flush_active;

  // Last granted values, shown on the outputs while nothing is granted.
  logic [ROB_W-1:0] hold_rob;
  logic [31:0]      hold_addr;
  logic [ID_W-1:0]  hold_id;

  // Ages relative to the ROB head; modular subtraction handles wrap.
  always_comb begin
    age_flat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_age[i] = slot_rob[i] - rob_head;
      in_age[i]   = req_rob[i*ROB_W +: ROB_W] - rob_head;
      age_flat[i*ROB_W +: ROB_W] = slot_age[i];
    end
  end

  age_select #(
    .N    (NUM_REQ),
    .W    (ROB_W),
    .ID_W (ID_W)
  ) u_age_select (
    .valid (slot_valid),
    .age   (age_flat),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Grant and flush qualification. The flush threshold is the new branch
  // age on the cf grant edge, then the latched branch age until NORMAL.
  always_comb begin
    grant        = (state == NORMAL) && sel_found;
    grant_cf     = grant && slot_cf[sel_idx];
    sel_age      = slot_age[sel_idx];
    flush_active = (state != NORMAL) || grant_cf;
    flush_age    = grant_cf ? sel_age : branch_age;
  end

  assign req_ready = ~slot_valid;

  // Holding slots: clear on grant or flush, capture when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      slot_cf    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_rob[i]  <= '0;
        slot_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (slot_valid[i]) begin
          if ((grant && (sel_idx == ID_W'(i))) ||
              (flush_active && (slot_age[i] > flush_age))) begin
            slot_valid[i] <= 1'b0;
          end
        end else if (req_valid[i]) begin
          slot_valid[i] <= !(flush_active && (in_age[i] > flush_age));
          slot_rob[i]   <= req_rob[i*ROB_W +: ROB_W];
          slot_cf[i]    <= req_cf[i];
          slot_addr[i]  <= req_addr[i*32 +: 32];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= NORMAL;
    else     state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      NORMAL:  if (grant_cf)       state_next = CF_WAIT;
      CF_WAIT: if (recover)        state_next = RECOVER;
      RECOVER: if (changeFlow_out) state_next = NORMAL;
      default:                     state_next = NORMAL;
    endcase
  end

  // Branch age and last-grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_age <= '0;
      hold_rob   <= '0;
      hold_addr  <= '0;
      hold_id    <= '0;
    end else begin
      if (grant_cf) branch_age <= sel_age;
      if (grant) begin
        hold_rob  <= slot_rob[sel_idx];
        hold_addr <= slot_addr[sel_idx];
        hold_id   <= sel_idx;
      end
    end
  end

  // FSM outputs: all driven from slot registers, state and held values.
  always_comb begin
    complete   = grant;
    changeFlow = grant_cf;
    rob_number = hold_rob;
    jb_addr    = hold_addr;
    grant_id   = hold_id;
    if (grant) begin
      rob_number = slot_rob[sel_idx];
      jb_addr    = slot_addr[sel_idx];
      grant_id   = sel_idx;
    end
    rec_busy = (state != NORMAL);
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed bench for complete_arbiter with a grant scoreboard.
module tb_complete_arbiter;

  localparam int N   = 3;
  localparam int RW  = 4;
  localparam int EXP_W = RW + 1 + 32 + 2;  // {rob, cf, addr, id}

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*RW-1:0] req_rob;
  logic [N-1:0]    req_cf;
  logic [N*32-1:0] req_addr;
  logic [RW-1:0]   rob_head;
  logic            recover;
  logic            changeFlow_out;
  logic            complete;
  logic [RW-1:0]   rob_number;
  logic            changeFlow;
  logic [31:0]     jb_addr;
  logic [1:0]      grant_id;
  logic            rec_busy;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_e;
  int checks   = 0;
  int failures = 0;

  complete_arbiter #(.NUM_REQ(N), .ROB_W(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rob        (req_rob),
    .req_cf         (req_cf),
    .req_addr       (req_addr),
    .rob_head       (rob_head),
    .recover        (recover),
    .changeFlow_out (changeFlow_out),
    .complete       (complete),
    .rob_number     (rob_number),
    .changeFlow     (changeFlow),
    .jb_addr        (jb_addr),
    .grant_id       (grant_id),
    .rec_busy       (rec_busy)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [EXP_W-1:0] mk(input logic [RW-1:0] rob, input logic cf,
                                          input logic [31:0] addr, input logic [1:0] id);
    return {rob, cf, addr, id};
  endfunction

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [RW-1:0] rob, input logic cf,
                         input logic [31:0] addr);
    req_valid[i]          = 1'b1;
    req_rob[i*RW +: RW]   = rob;
    req_cf[i]             = cf;
    req_addr[i*32 +: 32]  = addr;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_cf    = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d grants outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor: every completion must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && complete === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_complete: rob_number=%0d grant_id=%0d, required no grant",
                 rob_number, grant_id);
      end else begin
        exp_e = exp_q.pop_front();
        check("sb_rob_number", 64'(rob_number), 64'(exp_e[EXP_W-1 -: RW]));
        check("sb_changeFlow", 64'(changeFlow), 64'(exp_e[34]));
        check("sb_grant_id",   64'(grant_id),   64'(exp_e[1:0]));
        if (exp_e[34]) check("sb_jb_addr", 64'(jb_addr), 64'(exp_e[33:2]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_rob = '0; req_cf = '0; req_addr = '0;
    rob_head = '0; recover = 1'b0; changeFlow_out = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_complete",   64'(complete),   64'd0);
    check("rst_req_ready",  64'(req_ready),  64'b111);
    check("rst_rec_busy",   64'(rec_busy),   64'd0);
    check("rst_changeFlow", 64'(changeFlow), 64'd0);
    check("rst_outputs",    64'({rob_number, jb_addr, grant_id}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Wrapped ages: head 14, MUL rob 15 (age 1) before ALU rob 1 (age 3).
    rob_head = 4'd14;
    set_req(0, 4'd1,  1'b0, 32'h1000);
    set_req(1, 4'd15, 1'b0, 32'h2000);
    exp_q.push_back(mk(4'd15, 1'b0, 32'h0, 2'd1));
    exp_q.push_back(mk(4'd1,  1'b0, 32'h0, 2'd0));
    tick();
    clear_req();
    wait_drain("wrap_age", 6);
    tick();

    // Mispredict: ALU rob 3 cf granted ahead of LD rob 5; LD flushed.
    rob_head = 4'd0;
    set_req(0, 4'd3, 1'b1, 32'h40);
    set_req(2, 4'd5, 1'b0, 32'h500);
    exp_q.push_back(mk(4'd3, 1'b1, 32'h40, 2'd0));
    tick();
    clear_req();
    @(negedge clk);
    check("cf_changeFlow", 64'(changeFlow), 64'd1);
    check("cf_jb_addr",    64'(jb_addr),    64'h40);
    tick();
    check("cf_rec_busy",   64'(rec_busy),   64'd1);
    check("cf_ld_flushed", 64'(req_ready),  64'b111);

    // Older MUL rob 2 held; younger LD rob 7 accepted and dropped.
    set_req(1, 4'd2, 1'b0, 32'h200);
    set_req(2, 4'd7, 1'b0, 32'h700);
    tick();
    clear_req();
    check("cfw_ready", 64'(req_ready), 64'b101);
    recover = 1'b1;
    tick();
    recover = 1'b0;
    repeat (2) tick();
    check("rec_busy_recover", 64'(rec_busy), 64'd1);
    exp_q.push_back(mk(4'd2, 1'b0, 32'h0, 2'd1));
    changeFlow_out = 1'b1;
    tick();
    changeFlow_out = 1'b0;
    @(negedge clk);
    check("held_complete", 64'(complete),   64'd1);
    check("held_rob",      64'(rob_number), 64'd2);
    wait_drain("held", 4);
    repeat (3) tick();
    check("after_rec_busy", 64'(rec_busy), 64'd0);

    // Two cf slots: only rob 6 (age 2) completes, rob 8 (age 4) flushed.
    rob_head = 4'd4;
    set_req(0, 4'd6, 1'b1, 32'h100);
    set_req(1, 4'd8, 1'b1, 32'h200);
    exp_q.push_back(mk(4'd6, 1'b1, 32'h100, 2'd0));
    tick();
    clear_req();
    tick();
    check("two_cf_ready", 64'(req_ready), 64'b111);
    recover = 1'b1;
    tick();
    recover = 1'b0;
    changeFlow_out = 1'b1;
    tick();
    changeFlow_out = 1'b0;
    repeat (4) tick();
    wait_drain("two_cf", 2);

    // Reset during RECOVER with two slots full.
    rob_head = 4'd0;
    set_req(0, 4'd5, 1'b1, 32'hC0);
    exp_q.push_back(mk(4'd5, 1'b1, 32'hC0, 2'd0));
    tick();
    clear_req();
    tick();
    set_req(1, 4'd2, 1'b0, 32'h220);
    set_req(2, 4'd3, 1'b0, 32'h330);
    tick();
    clear_req();
    recover = 1'b1;
    tick();
    recover = 1'b0;
    check("pre_rst_ready", 64'(req_ready), 64'b001);
    check("pre_rst_busy",  64'(rec_busy),  64'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_ready", 64'(req_ready), 64'b111);
    check("async_rst_busy",  64'(rec_busy),  64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_complete", 64'(complete),  64'd0);
    check("post_rst_ready",    64'(req_ready), 64'b111);
    check("post_rst_busy",     64'(rec_busy),  64'd0);
    repeat (3) tick();
    wait_drain("mid_rec_rst", 2);

    // Three full slots, robs 9/10/11: back-to-back grants in age order.
    rob_head = 4'd0;
    set_req(0, 4'd11, 1'b0, 32'hB0);
    set_req(1, 4'd9,  1'b0, 32'h90);
    set_req(2, 4'd10, 1'b0, 32'hA0);
    exp_q.push_back(mk(4'd9,  1'b0, 32'h0, 2'd1));
    exp_q.push_back(mk(4'd10, 1'b0, 32'h0, 2'd2));
    exp_q.push_back(mk(4'd11, 1'b0, 32'h0, 2'd0));
    tick();
    clear_req();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_bubble", 64'(complete), 64'd1);
    end
    wait_drain("three_full", 4);
    repeat (2) tick();
    check("idle_ready", 64'(req_ready), 64'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
